// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: issue/bubble/hold decisions, EX and MEM
// destination tracking, operand forwarding selects and taken-jump flush sequencing.
module ex_hazard_ctrl #(
  parameter int unsigned MUL_LAT   = 3,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_optype,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       jmp_en,
  output logic       stall_if,
  output logic       stall_id,
  output logic       flush_id,
  output logic       ex_valid,
  output logic       ex_hold,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic [1:0] state
);

  // I_* optype encodings shared with decode and the ALU wrapper.
  localparam logic [4:0] I_NOP   = 5'd0;
  localparam logic [4:0] I_LW    = 5'd1;
  localparam logic [4:0] I_SW    = 5'd2;
  localparam logic [4:0] I_ADDI  = 5'd3;
  localparam logic [4:0] I_ADD   = 5'd4;
  localparam logic [4:0] I_SUB   = 5'd5;
  localparam logic [4:0] I_MUL   = 5'd6;
  localparam logic [4:0] I_MULH  = 5'd7;
  localparam logic [4:0] I_XOR   = 5'd8;
  localparam logic [4:0] I_AND   = 5'd9;
  localparam logic [4:0] I_OR    = 5'd10;
  localparam logic [4:0] I_LUI   = 5'd11;
  localparam logic [4:0] I_AUIPC = 5'd12;
  localparam logic [4:0] I_BEQ   = 5'd13;
  localparam logic [4:0] I_BNE   = 5'd14;
  localparam logic [4:0] I_BLT   = 5'd15;
  localparam logic [4:0] I_BGE   = 5'd16;
  localparam logic [4:0] I_JAL   = 5'd17;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic       ex_valid_q;
  logic [4:0] ex_rd_q;
  logic       ex_wr_q, ex_load_q;
  logic       mem_valid_q;
  logic [4:0] mem_rd_q;
  logic       mem_wr_q;

  logic is_wr, is_load, is_mul;
  logic load_use;
  logic stall, do_issue, do_bubble, mem_adv;
  logic ex_fwd_ok, mem_fwd_ok;

  always_comb begin
    is_wr   = 1'b0;
    is_load = 1'b0;
    is_mul  = 1'b0;
    case (id_optype)
      I_LW: begin
        is_wr   = 1'b1;
        is_load = 1'b1;
      end
      I_ADDI, I_ADD, I_SUB, I_XOR, I_AND, I_OR, I_LUI, I_AUIPC: is_wr = 1'b1;
      I_MUL, I_MULH: begin
        is_wr  = 1'b1;
        is_mul = 1'b1;
      end
      default: ;
    endcase
  end

  assign load_use = id_valid & ex_valid_q & ex_load_q & (ex_rd_q != 5'd0) &
                    ((id_rs1 == ex_rd_q) | (id_rs2 == ex_rd_q));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    flush_id  = 1'b0;
    ex_hold   = 1'b0;
    do_issue  = 1'b0;
    do_bubble = 1'b0;
    mem_adv   = 1'b1;
    case (state_q)
      RUN: begin
        if (jmp_en) begin
          // Flush beats a load-use stall: the dependent instruction is discarded anyway.
          flush_id  = 1'b1;
          do_bubble = 1'b1;
          cnt_d     = 4'(FLUSH_CYC - 1);
          state_d   = (FLUSH_CYC > 1) ? FLUSH : RUN;
        end else if (load_use) begin
          stall     = 1'b1;
          do_bubble = 1'b1;
        end else begin
          do_issue = 1'b1;
          if (id_valid && is_mul && (MUL_LAT > 1)) begin
            cnt_d   = 4'(MUL_LAT - 2);
            state_d = MUL_WAIT;
          end
        end
      end
      MUL_WAIT: begin
        ex_hold = 1'b1;
        stall   = 1'b1;
        mem_adv = (cnt_q == 4'd0);
        if (cnt_q == 4'd0) state_d = RUN;
        else cnt_d = cnt_q - 4'd1;
      end
      FLUSH: begin
        // cnt holds the remaining FLUSH cycles including this one.
        flush_id  = 1'b1;
        do_bubble = 1'b1;
        cnt_d     = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= 5'd0;
      ex_wr_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= 5'd0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (do_issue) begin
        ex_valid_q <= id_valid;
        ex_rd_q    <= id_rd;
        ex_wr_q    <= id_valid & is_wr;
        ex_load_q  <= id_valid & is_load;
      end else if (do_bubble) begin
        ex_valid_q <= 1'b0;
        ex_wr_q    <= 1'b0;
        ex_load_q  <= 1'b0;
      end
      if (mem_adv) begin
        mem_valid_q <= ex_valid_q;
        mem_rd_q    <= ex_rd_q;
        mem_wr_q    <= ex_wr_q;
      end else begin
        mem_valid_q <= 1'b0;
      end
    end
  end

  // A load's data is not ready in EX, so it may only forward from MEM.
  assign ex_fwd_ok  = ex_valid_q & ex_wr_q & ~ex_load_q & (ex_rd_q != 5'd0);
  assign mem_fwd_ok = mem_valid_q & mem_wr_q & (mem_rd_q != 5'd0);

  always_comb begin
    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
    if (id_valid) begin
      if (ex_fwd_ok && (id_rs1 == ex_rd_q))        fwd_a_sel = 2'd1;
      else if (mem_fwd_ok && (id_rs1 == mem_rd_q)) fwd_a_sel = 2'd2;
      if (ex_fwd_ok && (id_rs2 == ex_rd_q))        fwd_b_sel = 2'd1;
      else if (mem_fwd_ok && (id_rs2 == mem_rd_q)) fwd_b_sel = 2'd2;
    end
  end

  assign stall_if = stall;
  assign stall_id = stall;
  assign ex_valid = ex_valid_q;
  assign state    = state_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: per-cycle expected control vectors are queued
// as stimulus is driven and compared against the DUT outputs mid-cycle.
module tb_ex_hazard_ctrl;

  localparam logic [4:0] I_NOP = 5'd0;
  localparam logic [4:0] I_LW  = 5'd1;
  localparam logic [4:0] I_ADD = 5'd4;
  localparam logic [4:0] I_SUB = 5'd5;
  localparam logic [4:0] I_MUL = 5'd6;
  localparam logic [4:0] I_AND = 5'd9;
  localparam logic [4:0] I_OR  = 5'd10;
  localparam logic [4:0] I_BEQ = 5'd13;

  localparam int W = 11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_optype, id_rs1, id_rs2, id_rd;
  logic       jmp_en;
  logic       stall_if, stall_id, flush_id, ex_valid, ex_hold;
  logic [1:0] fwd_a_sel, fwd_b_sel, state;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;

  wire [W-1:0] obs = {stall_if, stall_id, flush_id, ex_valid, ex_hold,
                      fwd_a_sel, fwd_b_sel, state};

  ex_hazard_ctrl #(.MUL_LAT(3), .FLUSH_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_optype(id_optype),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .jmp_en(jmp_en),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
    .ex_valid(ex_valid), .ex_hold(ex_hold), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation budget exceeded, errors %0d", errors);
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] ev(input logic si, input logic sd, input logic fl,
                                      input logic exv, input logic hold,
                                      input logic [1:0] fa, input logic [1:0] fb,
                                      input logic [1:0] st);
    return {si, sd, fl, exv, hold, fa, fb, st};
  endfunction

  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic jmp);
    id_valid  = v;
    id_optype = op;
    id_rs1    = rs1;
    id_rs2    = rs2;
    id_rd     = rd;
    jmp_en    = jmp;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] exp_v);
    logic [W-1:0] e;
    string        t;
    exp_q.push_back(exp_v);
    tag_q.push_back(tag);
    #2;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", t, obs, e);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [W-1:0] exp_v);
    chk(tag, exp_v);
    adv();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, I_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("reset", ev(0,0,0,0,0,2'd0,2'd0,2'd0));
    adv();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("idle", ev(0,0,0,0,0,2'd0,2'd0,2'd0));

    // EX then MEM forwarding
    drive(1'b1, I_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    step("add_issue", ev(0,0,0,0,0,2'd0,2'd0,2'd0));
    drive(1'b1, I_SUB, 5'd3, 5'd1, 5'd4, 1'b0);
    step("fwd_ex", ev(0,0,0,1,0,2'd1,2'd0,2'd0));
    drive(1'b1, I_OR, 5'd4, 5'd3, 5'd9, 1'b0);
    step("fwd_ex_mem", ev(0,0,0,1,0,2'd1,2'd2,2'd0));
    drive(1'b0, I_NOP, 5'd9, 5'd4, 5'd0, 1'b0);
    step("no_fwd_invalid", ev(0,0,0,1,0,2'd0,2'd0,2'd0));

    // load-use bubble
    drive(1'b1, I_LW, 5'd2, 5'd0, 5'd5, 1'b0);
    step("lw_issue", ev(0,0,0,0,0,2'd0,2'd0,2'd0));
    drive(1'b1, I_ADD, 5'd5, 5'd0, 5'd6, 1'b0);
    step("load_use_stall", ev(1,1,0,1,0,2'd0,2'd0,2'd0));
    step("load_use_bubble", ev(0,0,0,0,0,2'd2,2'd0,2'd0));

    // multi-cycle MUL hold
    drive(1'b1, I_MUL, 5'd6, 5'd1, 5'd7, 1'b0);
    step("mul_issue", ev(0,0,0,1,0,2'd1,2'd0,2'd0));
    drive(1'b1, I_AND, 5'd7, 5'd6, 5'd11, 1'b0);
    step("mul_wait1", ev(1,1,0,1,1,2'd1,2'd2,2'd1));
    step("mul_wait2", ev(1,1,0,1,1,2'd1,2'd0,2'd1));
    step("mul_last", ev(0,0,0,1,0,2'd1,2'd0,2'd0));

    // jump coinciding with load-use: flush wins
    drive(1'b1, I_LW, 5'd1, 5'd0, 5'd12, 1'b0);
    step("lw2_issue", ev(0,0,0,1,0,2'd0,2'd0,2'd0));
    drive(1'b1, I_ADD, 5'd12, 5'd0, 5'd13, 1'b1);
    step("jmp_over_stall", ev(0,0,1,1,0,2'd0,2'd0,2'd0));
    drive(1'b0, I_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    step("flush1", ev(0,0,1,0,0,2'd0,2'd0,2'd2));
    step("flush_done", ev(0,0,0,0,0,2'd0,2'd0,2'd0));

    // plain taken branch
    drive(1'b1, I_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    step("beq_issue", ev(0,0,0,0,0,2'd0,2'd0,2'd0));
    drive(1'b1, I_ADD, 5'd1, 5'd1, 5'd14, 1'b1);
    step("beq_taken", ev(0,0,1,1,0,2'd0,2'd0,2'd0));
    drive(1'b0, I_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    step("beq_flush", ev(0,0,1,0,0,2'd0,2'd0,2'd2));
    step("beq_done", ev(0,0,0,0,0,2'd0,2'd0,2'd0));

    // reset during MUL_WAIT
    drive(1'b1, I_MUL, 5'd1, 5'd2, 5'd15, 1'b0);
    step("mul2_issue", ev(0,0,0,0,0,2'd0,2'd0,2'd0));
    drive(1'b1, I_OR, 5'd15, 5'd0, 5'd16, 1'b0);
    chk("mul2_wait", ev(1,1,0,1,1,2'd1,2'd0,2'd1));
    #1;
    rst_n = 1'b0;
    chk("rst_in_mul", ev(0,0,0,0,0,2'd0,2'd0,2'd0));
    adv();
    chk("rst_held", ev(0,0,0,0,0,2'd0,2'd0,2'd0));
    rst_n = 1'b1;
    drive(1'b1, I_OR, 5'd1, 5'd2, 5'd16, 1'b0);
    step("post_rst_issue", ev(0,0,0,0,0,2'd0,2'd0,2'd0));
    drive(1'b1, I_SUB, 5'd16, 5'd15, 5'd17, 1'b0);
    step("post_rst_fwd", ev(0,0,0,1,0,2'd1,2'd0,2'd0));
    drive(1'b0, I_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    step("final", ev(0,0,0,1,0,2'd0,2'd0,2'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
